// File: rtl/eq_d.sv
// 5/3 (LeGall) reversible lifting core: predict step yields detail d3,
// update step yields approximation a2 one clock later from the two neighbouring details.
module eq_d #(
    parameter int W = 10
) (
    output logic signed [W-1:0] d3,
    output logic signed [W-1:0] a2,
    input  logic                clk,
    input  logic signed [W-1:0] x2,
    input  logic signed [W-1:0] x3,
    input  logic signed [W-1:0] x4,
    input  logic                rst
);

    localparam int XW = W + 2;

    logic signed [XW-1:0] x2_e, x3_e, x4_e;
    logic signed [XW-1:0] pair_sum;
    logic signed [XW-1:0] dprev_e, d3_e, x2q_e;
    logic signed [XW-1:0] upd_sum;

    logic signed [W-1:0] d3_d, d3_q;
    logic signed [W-1:0] a2_d, a2_q;
    logic signed [W-1:0] d_prev_d, d_prev_q;
    logic signed [W-1:0] x2_d, x2_q;

    // NOTE: every variable gets a value on every pass through this block, so no latch is inferred.
    always_comb begin
        x2_e     = {{2{x2[W-1]}}, x2};
        x3_e     = {{2{x3[W-1]}}, x3};
        x4_e     = {{2{x4[W-1]}}, x4};
        pair_sum = x2_e + x4_e;
        // >>> on a signed operand floors toward minus infinity; the cast wraps to W bits.
        d3_d     = W'(x3_e - (pair_sum >>> 1));

        // Update uses the pre-edge detail pair (left = d_prev_q, right = d3_q).
        dprev_e  = {{2{d_prev_q[W-1]}}, d_prev_q};
        d3_e     = {{2{d3_q[W-1]}}, d3_q};
        x2q_e    = {{2{x2_q[W-1]}}, x2_q};
        upd_sum  = dprev_e + d3_e + XW'(2);
        a2_d     = W'(x2q_e + (upd_sum >>> 2));

        d_prev_d = d3_q;
        x2_d     = x2;
    end

    // NOTE: non-blocking assignments so every flop samples the old values of the others at the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            d3_q     <= '0;
            a2_q     <= '0;
            d_prev_q <= '0;
            x2_q     <= '0;
        end else begin
            d3_q     <= d3_d;
            a2_q     <= a2_d;
            d_prev_q <= d_prev_d;
            x2_q     <= x2_d;
        end
    end

    assign d3 = d3_q;
    assign a2 = a2_q;

endmodule

// File: tb/tb_eq_d.sv
// Self-checking bench for eq_d: directed vector table plus a random stream checked
// against an independent integer model through an expectation queue.
module tb_eq_d;

    localparam int W = 10;

    logic                clk;
    logic                rst;
    logic signed [W-1:0] x2, x3, x4;
    logic signed [W-1:0] d3, a2;

    int tests  = 0;
    int failed = 0;

    eq_d #(.W(W)) dut (
        .d3 (d3),
        .a2 (a2),
        .clk(clk),
        .x2 (x2),
        .x3 (x3),
        .x4 (x4),
        .rst(rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string name;
        bit    rst;
        int    x2, x3, x4;
        int    d3, a2;
    } vec_t;

    typedef struct {
        string name;
        int    d3, a2;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    // Reference model state (integer arithmetic, floor division by hand).
    int m_d3 = 0, m_dprev = 0, m_x2q = 0;

    function automatic int wrap_w(input int v);
        int r;
        r = v % 1024;
        if (r < 0) r += 1024;
        if (r >= 512) r -= 1024;
        return r;
    endfunction

    function automatic int floor_div(input int v, input int k);
        int q;
        q = v / k;
        if ((v % k) != 0 && v < 0) q -= 1;
        return q;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            failed++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic add(input string name, input bit r, input int a, input int b, input int c,
                       input int ed, input int ea);
        vec_t v;
        v.name = name; v.rst = r; v.x2 = a; v.x3 = b; v.x4 = c; v.d3 = ed; v.a2 = ea;
        vecs.push_back(v);
    endtask

    // Advance the model one edge; returns the outputs it predicts after that edge.
    task automatic model_step(input bit r, input int a, input int b, input int c,
                              output int ed, output int ea);
        if (r) begin
            ed = 0; ea = 0;
            m_dprev = 0; m_x2q = 0;
        end else begin
            ed = wrap_w(b - floor_div(a + c, 2));
            ea = wrap_w(m_x2q + floor_div(m_dprev + m_d3 + 2, 4));
            m_dprev = m_d3; m_x2q = a;
        end
        m_d3 = ed;
    endtask

    // Drive one edge's worth of inputs, push the expectation, compare after the edge.
    task automatic apply(input string name, input bit r, input int a, input int b, input int c,
                         input int ed, input int ea);
        exp_t e, got;
        @(negedge clk);
        rst = r;
        x2 = W'(a); x3 = W'(b); x4 = W'(c);
        e.name = name; e.d3 = ed; e.a2 = ea;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 0, 1);
        end else begin
            got = sb.pop_front();
            check({got.name, "_d3"}, int'(d3), got.d3);
            check({got.name, "_a2"}, int'(a2), got.a2);
        end
    endtask

    initial begin
        int ed, ea;
        int ra, rb, rc;
        bit rr;

        rst = 1'b1; x2 = '0; x3 = '0; x4 = '0;

        add("rst0",      1, 123, -45, 300,     0,    0);
        add("rst1",      1, -7, 400, -300,     0,    0);
        add("rel0",      0, 164, 164, 164,     0,    0);
        add("rel1",      0, 164, 164, 164,     0,  164);
        add("pred0",     0, 164, 164, 156,     4,  164);
        add("pred1",     0, 164, 164, 156,     4,  165);
        add("pred2",     0, 164, 164, 156,     4,  166);
        add("upd0",      0, 108, 200, 254,    19,  166);
        add("upd1",      0, 108, 200, 254,    19,  114);
        add("upd2",      0, 108, 200, 254,    19,  118);
        add("mrst",      1, 108, 200, 254,     0,    0);
        add("mrst1",     0, 108, 200, 254,    19,    0);
        add("mrst2",     0, 108, 200, 254,    19,  113);
        add("mrst3",     0, 108, 200, 254,    19,  118);
        add("neg0",      0, 254,   0, 254,  -254,  118);
        add("neg1",      0, 254,   0, 254,  -254,  195);
        add("neg2",      0, 254,   0, 254,  -254,  127);
        add("wrap0",     0, -512, 511, -512,   -1,  127);
        add("wrap1",     0, -512, 511, -512,   -1,  448);
        add("wrap2",     0, -512, 511, -512,   -1, -512);
        add("floor0",    0,  -1,   0,  -2,     2, -512);
        add("floor1",    0,  -1,   0,  -2,     2,   -1);

        foreach (vecs[i]) begin
            apply(vecs[i].name, vecs[i].rst, vecs[i].x2, vecs[i].x3, vecs[i].x4,
                  vecs[i].d3, vecs[i].a2);
            model_step(vecs[i].rst, vecs[i].x2, vecs[i].x3, vecs[i].x4, ed, ea);
        end

        // Random stream with occasional mid-stream resets, checked against the model.
        for (int i = 0; i < 300; i++) begin
            rr = ($urandom_range(0, 15) == 0);
            ra = int'($urandom_range(0, 1023)) - 512;
            rb = int'($urandom_range(0, 1023)) - 512;
            rc = int'($urandom_range(0, 1023)) - 512;
            if (i % 50 == 7) begin
                ra = -512; rc = -512; rb = 511;
            end
            model_step(rr, ra, rb, rc, ed, ea);
            apply("rand", rr, ra, rb, rc, ed, ea);
        end

        check("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
